// File: rtl/i2s_audio_in.sv
// i2s_audio_in: master-mode I2S receiver for the stereo guitar ADC.
// Derives mclk/bclk/lrclk from the system clock with one free-running 10-bit counter.
// Shifts in the ADC data line using the standard one-bit I2S delay.
// Presents each left/right pair together, with a one-clk valid strobe.
//
// Ports:
//   clk       system clock (clk_mhz MHz; the divider ratios assume 50)
//   rst_n     asynchronous active-low reset
//   AI_mclk   ADC master clock, clk/4
//   AI_bclk   bit clock, clk/16
//   AI_lrclk  word select, clk/1024 (low = left, high = right)
//   AI_sdata  serial data from the ADC, changes on falling bclk
//   left_out  last complete left sample (upper in_res bits, two's complement)
//   right_out last complete right sample
//   valid     one-clk pulse when left_out/right_out update
module i2s_audio_in #(
  parameter int unsigned clk_mhz = 50,
  parameter int unsigned in_res  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              AI_mclk,
  output logic              AI_bclk,
  output logic              AI_lrclk,
  input  logic              AI_sdata,
  output logic [in_res-1:0] left_out,
  output logic [in_res-1:0] right_out,
  output logic              valid
);

  if (clk_mhz != 50 || in_res < 8 || in_res > 31) begin : g_bad_param
    $error("i2s_audio_in: unsupported clk_mhz or in_res");
  end

  logic [9:0]        cnt_q, cnt_d;
  logic [1:0]        sync_q, sync_d;
  logic [in_res-1:0] sr_q, sr_d;
  logic [in_res-1:0] hold_q, hold_d;
  logic [in_res-1:0] left_q, left_d;
  logic [in_res-1:0] right_q, right_d;
  logic              valid_q, valid_d;
  logic              mclk_q, bclk_q, lrclk_q;

  logic [4:0] slot;
  logic       in_window;
  logic       sample;

  assign slot      = cnt_q[8:4];
  // Slot 0 holds the I2S delay bit; slots past in_res are truncated ADC LSBs.
  assign in_window = (slot != 5'd0) && (32'(slot) <= in_res);
  // cnt[3:0]==B sits mid-way through the stable half of the bit.
  assign sample    = (cnt_q[3:0] == 4'hB) && in_window;

  always_comb begin
    cnt_d   = cnt_q + 10'd1;
    sync_d  = {sync_q[0], AI_sdata};
    sr_d    = sr_q;
    hold_d  = hold_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;

    if (cnt_q[8:0] == 9'd0) begin
      sr_d = '0;
    end else if (sample) begin
      sr_d = {sr_q[in_res-2:0], sync_q[1]};
    end

    // Park the left word so both channels publish on the same edge.
    if (cnt_q == 10'h1FF) begin
      hold_d = sr_q;
    end

    if (cnt_q == 10'h3FF) begin
      left_d  = hold_q;
      right_d = sr_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sync_q  <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      mclk_q  <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      // Registered from the next count so each clock output tracks cnt bit-for-bit.
      mclk_q  <= cnt_d[1];
      bclk_q  <= cnt_d[3];
      lrclk_q <= cnt_d[9];
    end
  end

  assign AI_mclk   = mclk_q;
  assign AI_bclk   = bclk_q;
  assign AI_lrclk  = lrclk_q;
  assign left_out  = left_q;
  assign right_out = right_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_i2s_audio_in.sv
// Bench for i2s_audio_in: runs an in_res=16 and an in_res=24 instance from one ADC model.
// A driver pushes the expected pair for each frame; per-instance monitors pop on valid.
module tb_i2s_audio_in;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdata = 1'b0;

  always #5 clk = ~clk;

  logic        mclk16, bclk16, lrclk16, valid16;
  logic [15:0] left16, right16;
  logic        mclk24, bclk24, lrclk24, valid24;
  logic [23:0] left24, right24;

  i2s_audio_in #(.clk_mhz(50), .in_res(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .AI_mclk   (mclk16),
    .AI_bclk   (bclk16),
    .AI_lrclk  (lrclk16),
    .AI_sdata  (sdata),
    .left_out  (left16),
    .right_out (right16),
    .valid     (valid16)
  );

  i2s_audio_in #(.clk_mhz(50), .in_res(24)) dut24 (
    .clk       (clk),
    .rst_n     (rst_n),
    .AI_mclk   (mclk24),
    .AI_bclk   (bclk24),
    .AI_lrclk  (lrclk24),
    .AI_sdata  (sdata),
    .left_out  (left24),
    .right_out (right24),
    .valid     (valid24)
  );

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  pair_t q16[$];
  pair_t q24[$];
  int n_cmp = 0;
  int n_err = 0;

  // ADC model state: 24-bit words, delay-slot bit and fill for slots past the LSB.
  logic [23:0] w_l = '0;
  logic [23:0] w_r = '0;
  logic        slot0_bit = 1'b0;
  logic        fill_bit = 1'b0;

  function automatic logic adc_bit(input logic lr, input int idx);
    logic [23:0] w;
    w = lr ? w_r : w_l;
    if (idx == 0) return slot0_bit;
    if (idx <= 24) return w[24-idx];
    return fill_bit;
  endfunction

  // ADC: on each falling bclk, present the next bit; an lrclk change restarts at slot 0.
  int   adc_idx = 0;
  logic adc_last_lr = 1'b0;
  logic adc_prev_bclk = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      adc_idx = 0;
      adc_last_lr = 1'b0;
      adc_prev_bclk = 1'b0;
    end else begin
      if (adc_prev_bclk && !bclk16) begin
        if (lrclk16 != adc_last_lr) begin
          adc_idx = 0;
          adc_last_lr = lrclk16;
        end else begin
          adc_idx++;
        end
        sdata = adc_bit(lrclk16, adc_idx);
      end
      adc_prev_bclk = bclk16;
    end
  end

  // Monitor for the 16-bit instance.
  int gap16 = 0;
  always @(posedge clk) begin
    pair_t e;
    #1;
    if (!rst_n) begin
      gap16 = 0;
    end else begin
      gap16++;
      if (valid16) begin
        n_cmp++;
        if (gap16 != 1024) begin
          n_err++;
          $display("FAIL valid16_spacing: got %0d clks, want 1024", gap16);
        end
        n_cmp++;
        if (q16.size() == 0) begin
          n_err++;
          $display("FAIL valid16_unexpected: got valid with L=%h R=%h, want no valid",
                   left16, right16);
        end else begin
          e = q16.pop_front();
          if (left16 !== e.l[23:8] || right16 !== e.r[23:8]) begin
            n_err++;
            $display("FAIL pair16: got L=%h R=%h, want L=%h R=%h",
                     left16, right16, e.l[23:8], e.r[23:8]);
          end
        end
        gap16 = 0;
      end
    end
  end

  // Monitor for the 24-bit instance.
  int gap24 = 0;
  always @(posedge clk) begin
    pair_t e;
    #1;
    if (!rst_n) begin
      gap24 = 0;
    end else begin
      gap24++;
      if (valid24) begin
        n_cmp++;
        if (gap24 != 1024) begin
          n_err++;
          $display("FAIL valid24_spacing: got %0d clks, want 1024", gap24);
        end
        n_cmp++;
        if (q24.size() == 0) begin
          n_err++;
          $display("FAIL valid24_unexpected: got valid with L=%h R=%h, want no valid",
                   left24, right24);
        end else begin
          e = q24.pop_front();
          if (left24 !== e.l || right24 !== e.r) begin
            n_err++;
            $display("FAIL pair24: got L=%h R=%h, want L=%h R=%h", left24, right24, e.l, e.r);
          end
        end
        gap24 = 0;
      end
    end
  end

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    q16.push_back(p);
    q24.push_back(p);
  endtask

  task automatic set_words(input logic [23:0] l, input logic [23:0] r, input logic s0,
                           input logic fill);
    w_l = l;
    w_r = r;
    slot0_bit = s0;
    fill_bit = fill;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 1100; t++) begin
      @(posedge clk);
      #1;
      if (valid16) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no valid in 1100 clks, want one within 1024", name);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({mclk16, bclk16, lrclk16, valid16} !== 4'b0 || left16 !== '0 || right16 !== '0 ||
        {mclk24, bclk24, lrclk24, valid24} !== 4'b0 || left24 !== '0 || right24 !== '0) begin
      n_err++;
      $display("FAIL %s: got clk16=%b%b%b v16=%b L16=%h R16=%h clk24=%b%b%b v24=%b L24=%h R24=%h, want all 0",
               name, mclk16, bclk16, lrclk16, valid16, left16, right16,
               mclk24, bclk24, lrclk24, valid24, left24, right24);
    end
  endtask

  initial begin
    int clk_errs;
    logic [31:0] k;

    set_words(24'h123456, 24'hFEDCBA, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");

    // Nominal: first frame after release.
    push(24'h123456, 24'hFEDCBA);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge k after release: mclk = k[1], bclk = k[3], lrclk = k[9].
    clk_errs = 0;
    for (int i = 1; i < 1024; i++) begin
      @(posedge clk);
      #1;
      k = i;
      if (mclk16 !== k[1] || bclk16 !== k[3] || lrclk16 !== k[9] ||
          mclk24 !== k[1] || bclk24 !== k[3] || lrclk24 !== k[9]) begin
        if (clk_errs == 0)
          $display("FAIL clock_phase: at edge %0d got m/b/lr=%b%b%b, want %b%b%b",
                   i, mclk16, bclk16, lrclk16, k[1], k[3], k[9]);
        clk_errs++;
      end
    end
    n_cmp++;
    if (clk_errs != 0) n_err++;
    wait_valid("nominal1");

    // Nominal: second frame.
    push(24'h123456, 24'hFEDCBA);
    wait_valid("nominal2");

    // Full scale signed extremes.
    set_words(24'h7FFFFF, 24'h800000, 1'b0, 1'b0);
    push(24'h7FFFFF, 24'h800000);
    wait_valid("full_scale");

    // Delay bit set, data zero.
    set_words(24'h000000, 24'h000000, 1'b1, 1'b0);
    push(24'h000000, 24'h000000);
    wait_valid("delay_bit");

    // Delay bit clear, everything else one.
    set_words(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1);
    push(24'hFFFFFF, 24'hFFFFFF);
    wait_valid("delay_inverse");

    // Mixed pattern.
    set_words(24'hA5C3E1, 24'h0F1E2D, 1'b1, 1'b1);
    push(24'hA5C3E1, 24'h0F1E2D);
    wait_valid("mixed");

    // Mid-frame reset: the aborted frame carries data that must never surface.
    set_words(24'hAAAAAA, 24'h555555, 1'b0, 1'b0);
    repeat (600) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    set_words(24'h13579B, 24'h2468AC, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(24'h13579B, 24'h2468AC);
    wait_valid("post_reset");

    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (q16.size() != 0 || q24.size() != 0) begin
      n_err++;
      $display("FAIL queues_drained: got %0d/%0d pending, want 0/0", q16.size(), q24.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
